// File: rtl/accum_alu_pkg.sv
// accum_alu_pkg: shared types for the accumulator ALU.
//   op_e    : 3-bit opcode presented on alu_op
//   state_e : control FSM states (IDLE accepts ops, DIV runs the iterative divider)
package accum_alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 3'd0,
    OP_INC  = 3'd1,
    OP_CLR  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_MUL  = 3'd5,
    OP_DIV  = 3'd6,
    OP_MOD  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_e;

endpackage

// File: rtl/accum_alu_if.sv
// accum_alu_if: op handshake and result/status bundle between the control unit and the ALU.
//   op_valid/op_ready : op handshake (control unit -> ALU / ALU -> control unit)
//   alu_op, bus_out   : opcode and WIDTH-bit operand, sampled at the accept edge
//   d_out             : accumulator value
//   done/busy         : completion pulse / DIV-MOD iteration in progress
//   zero/carry/dz     : status flags of the accumulator and last completed op
interface accum_alu_if
  import accum_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic             op_valid;
  logic             op_ready;
  op_e              alu_op;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] d_out;
  logic             done;
  logic             busy;
  logic             zero;
  logic             carry;
  logic             dz;

  // Control unit side.
  modport master (
    output op_valid, alu_op, bus_out,
    input  op_ready, d_out, done, busy, zero, carry, dz
  );

  // ALU side.
  modport slave (
    input  op_valid, alu_op, bus_out,
    output op_ready, d_out, done, busy, zero, carry, dz
  );

endinterface

// File: rtl/accum_divider.sv
// accum_divider: restoring shift-subtract unsigned divider, one quotient bit per clock.
//   clk, rst     : clock, synchronous active-high reset (clears o_valid and iteration state)
//   i_start      : begin a division; operands sampled on this edge
//   i_dividend   : WIDTH-bit dividend
//   i_divisor    : WIDTH-bit divisor (caller guarantees non-zero)
//   o_quotient   : quotient, valid while o_valid is high
//   o_remainder  : remainder, valid while o_valid is high
//   o_valid      : one-cycle pulse, high when sampled at the WIDTH-th edge after start
module accum_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_valid
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;

  logic [WIDTH-1:0] w_rem_in;
  logic [WIDTH-1:0] w_quo_in;
  logic [WIDTH-1:0] w_dvs;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // The start edge already performs the first iteration, so the last one
  // lands on edge WIDTH-1 and the result is stable for the WIDTH-th edge.
  always_comb begin
    w_rem_in  = i_start ? '0 : r_rem;
    w_quo_in  = i_start ? i_dividend : r_quo;
    w_dvs     = i_start ? i_divisor : r_dvs;
    w_trial   = {w_rem_in, w_quo_in[WIDTH-1]};
    w_fits    = w_trial >= {1'b0, w_dvs};
    w_rem_nxt = w_fits ? WIDTH'(w_trial - {1'b0, w_dvs}) : WIDTH'(w_trial);
    w_quo_nxt = {w_quo_in[WIDTH-2:0], w_fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_start || (r_cnt != '0)) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_dvs <= w_dvs;
      end
      if (i_start) begin
        r_cnt <= CNT_W'(WIDTH - 1);
      end else if (r_cnt != '0) begin
        r_cnt   <= r_cnt - CNT_W'(1);
        r_valid <= (r_cnt == CNT_W'(1));
      end
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
  assign o_valid     = r_valid;

endmodule

// File: rtl/accum_alu.sv
// accum_alu: WIDTH-bit accumulator ALU with valid/ready op handshake, status flags,
// divide-by-zero detection and iterative DIV/MOD.
//   clk, rst : clock, synchronous active-high reset
//   bus      : accum_alu_if.slave (op_valid/op_ready, alu_op, bus_out, d_out,
//              done, busy, zero, carry, dz)
// Build option: define ACCUM_ALU_SAT_EN to saturate INC/ADD/MUL overflow to all ones
// and SUB borrow to zero; otherwise results wrap/truncate modulo 2^WIDTH.
module accum_alu
  import accum_alu_pkg::*;
#(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic        clk,
  input logic        rst,
  accum_alu_if.slave bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_d;
  logic             r_zero;
  logic             r_carry;
  logic             r_dz;
  logic             r_done;
  logic             r_is_mod;

  logic             w_accept;
  logic             w_is_divmod;
  logic             w_b_zero;
  logic             w_div_start;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic             w_mul_ovf;
  logic [WIDTH-1:0] w_add_res;
  logic [WIDTH-1:0] w_sub_res;
  logic [WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic             w_div_valid;

  logic             w_acc_we;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_carry_nxt;
  logic             w_dz_nxt;
  logic             w_done_nxt;

  assign w_accept    = bus.op_valid && (r_state == IDLE);
  assign w_is_divmod = (bus.alu_op == OP_DIV) || (bus.alu_op == OP_MOD);
  assign w_b_zero    = (bus.bus_out == '0);
  assign w_div_start = w_accept && w_is_divmod && !w_b_zero;

  // Shared adder serves INC (operand 1) and ADD (operand bus_out).
  assign w_sum     = {1'b0, r_d} + ((bus.alu_op == OP_INC) ? (WIDTH+1)'(1) : {1'b0, bus.bus_out});
  assign w_diff    = {1'b0, r_d} - {1'b0, bus.bus_out};
  assign w_prod    = {{WIDTH{1'b0}}, r_d} * {{WIDTH{1'b0}}, bus.bus_out};
  assign w_mul_ovf = |w_prod[2*WIDTH-1:WIDTH];

`ifdef ACCUM_ALU_SAT_EN
  assign w_add_res = w_sum[WIDTH]  ? '1 : w_sum[WIDTH-1:0];
  assign w_sub_res = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
  assign w_mul_res = w_mul_ovf     ? '1 : w_prod[WIDTH-1:0];
`else
  assign w_add_res = w_sum[WIDTH-1:0];
  assign w_sub_res = w_diff[WIDTH-1:0];
  assign w_mul_res = w_prod[WIDTH-1:0];
`endif

  accum_divider #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_start),
    .i_dividend  (r_d),
    .i_divisor   (bus.bus_out),
    .o_quotient  (w_quo),
    .o_remainder (w_rem),
    .o_valid     (w_div_valid)
  );

  // Next state and next accumulator/flag values.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_we    = 1'b0;
    w_acc_nxt   = r_d;
    w_carry_nxt = r_carry;
    w_dz_nxt    = r_dz;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_done_nxt  = 1'b1;
          w_carry_nxt = 1'b0;
          w_dz_nxt    = 1'b0;
          unique case (bus.alu_op)
            OP_LOAD: begin w_acc_we = 1'b1; w_acc_nxt = bus.bus_out; end
            OP_CLR:  begin w_acc_we = 1'b1; w_acc_nxt = RST_VAL; end
            OP_INC, OP_ADD: begin
              w_acc_we = 1'b1; w_acc_nxt = w_add_res; w_carry_nxt = w_sum[WIDTH];
            end
            OP_SUB: begin
              w_acc_we = 1'b1; w_acc_nxt = w_sub_res; w_carry_nxt = w_diff[WIDTH];
            end
            OP_MUL: begin
              w_acc_we = 1'b1; w_acc_nxt = w_mul_res; w_carry_nxt = w_mul_ovf;
            end
            OP_DIV, OP_MOD: begin
              // Divide by zero completes at once with the accumulator untouched.
              if (w_b_zero) begin
                w_dz_nxt = 1'b1;
              end else begin
                w_done_nxt  = 1'b0;
                w_carry_nxt = r_carry;
                w_dz_nxt    = r_dz;
                w_state_nxt = DIV;
              end
            end
            default: ;
          endcase
        end
      end
      DIV: begin
        if (w_div_valid) begin
          w_state_nxt = IDLE;
          w_acc_we    = 1'b1;
          w_acc_nxt   = r_is_mod ? w_rem : w_quo;
          w_carry_nxt = 1'b0;
          w_dz_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Accumulator and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d      <= RST_VAL;
      r_zero   <= (RST_VAL == '0);
      r_carry  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_is_mod <= 1'b0;
    end else begin
      r_carry <= w_carry_nxt;
      r_dz    <= w_dz_nxt;
      r_done  <= w_done_nxt;
      if (w_acc_we) begin
        r_d    <= w_acc_nxt;
        r_zero <= (w_acc_nxt == '0);
      end
      if (w_div_start) r_is_mod <= (bus.alu_op == OP_MOD);
    end
  end

  assign bus.op_ready = (r_state == IDLE);
  assign bus.busy     = (r_state == DIV);
  assign bus.d_out    = r_d;
  assign bus.zero     = r_zero;
  assign bus.carry    = r_carry;
  assign bus.dz       = r_dz;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_accum_alu.sv
// tb_accum_alu: randomized + directed bench for accum_alu (WIDTH=8, RST_VAL=0)
// against an integer-arithmetic reference model.
module tb_accum_alu;
  import accum_alu_pkg::*;

  localparam int unsigned W    = 8;
  localparam int          MAXV = (1 << W) - 1;
  localparam int          MODV = 1 << W;
`ifdef ACCUM_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;
  int   exp_d   = 0;

  accum_alu_if #(.WIDTH(W)) bus_if ();

  accum_alu #(.WIDTH(W), .RST_VAL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: result, carry and dz of one op applied to accumulator a.
  task automatic model(input int op, input int a, input int b,
                       output int res, output int cy, output int dz);
    int t;
    cy = 0; dz = 0; res = a;
    case (op)
      0: res = b;
      1, 3: begin
        t = a + ((op == 1) ? 1 : b);
        cy = (t > MAXV) ? 1 : 0;
        res = (cy != 0 && SAT) ? MAXV : t % MODV;
      end
      2: res = 0;
      4: begin
        cy = (b > a) ? 1 : 0;
        res = (cy != 0 && SAT) ? 0 : (a - b + MODV) % MODV;
      end
      5: begin
        t = a * b;
        cy = (t > MAXV) ? 1 : 0;
        res = (cy != 0 && SAT) ? MAXV : t % MODV;
      end
      default: begin
        if (b == 0) dz = 1;
        else        res = (op == 6) ? a / b : a % b;
      end
    endcase
  endtask

  task automatic do_op(input int op, input int b);
    int res, cy, dz, n;
    bit busy_ok;
    model(op, exp_d, b, res, cy, dz);
    @(negedge clk);
    check_val("ready_before", int'(bus_if.op_ready), 1);
    bus_if.op_valid = 1'b1;
    bus_if.alu_op   = op_e'(3'(op));
    bus_if.bus_out  = 8'(b);
    @(posedge clk); #1;
    bus_if.op_valid = 1'b0;
    if (op >= 6 && b != 0) begin
      check_val("div_busy", int'(bus_if.busy), 1);
      check_val("div_not_ready", int'(bus_if.op_ready), 0);
      n = 0;
      busy_ok = 1'b1;
      while (!bus_if.done && n < 20) begin
        if (!bus_if.busy || bus_if.op_ready || bus_if.d_out != 8'(exp_d)) busy_ok = 1'b0;
        // Offer a junk op while busy; it must be ignored.
        @(negedge clk);
        bus_if.op_valid = 1'b1;
        bus_if.alu_op   = op_e'(3'($urandom_range(0, 5)));
        bus_if.bus_out  = 8'($urandom);
        @(posedge clk); #1;
        bus_if.op_valid = 1'b0;
        n++;
      end
      check_val("div_latency", n, W);
      check_val("div_hold", int'(busy_ok), 1);
    end
    check_val("done", int'(bus_if.done), 1);
    check_val("busy_after", int'(bus_if.busy), 0);
    check_val("d_out", int'(bus_if.d_out), res);
    check_val("carry", int'(bus_if.carry), cy);
    check_val("dz", int'(bus_if.dz), dz);
    check_val("zero", int'(bus_if.zero), (res == 0) ? 1 : 0);
    exp_d = res;
  endtask

  task automatic idle_check();
    @(negedge clk);
    @(posedge clk); #1;
    check_val("done_pulse", int'(bus_if.done), 0);
    check_val("d_hold", int'(bus_if.d_out), exp_d);
  endtask

  initial begin
    int op, b, sel;
    bus_if.op_valid = 1'b0;
    bus_if.alu_op   = OP_LOAD;
    bus_if.bus_out  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_d", int'(bus_if.d_out), 0);
    check_val("rst_zero", int'(bus_if.zero), 1);
    check_val("rst_done", int'(bus_if.done), 0);
    check_val("rst_busy", int'(bus_if.busy), 0);
    check_val("rst_carry", int'(bus_if.carry), 0);
    check_val("rst_dz", int'(bus_if.dz), 0);
    check_val("rst_ready", int'(bus_if.op_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    do_op(0, 8'h05); do_op(3, 8'h03); idle_check();
    do_op(0, 8'hFF); do_op(1, 0); do_op(4, 8'h01);
    do_op(0, 8'h10); do_op(5, 8'h20);
    do_op(0, 8'h05); do_op(5, 8'h03);
    do_op(0, 8'h64); do_op(6, 8'h07);
    do_op(0, 8'h64); do_op(7, 8'h07);
    do_op(0, 8'h2A); do_op(6, 8'h00); do_op(3, 8'h01);
    do_op(2, 0);

    // Reset in the middle of a DIV.
    do_op(0, 8'h2B);
    @(negedge clk);
    bus_if.op_valid = 1'b1;
    bus_if.alu_op   = OP_DIV;
    bus_if.bus_out  = 8'h03;
    @(posedge clk); #1;
    bus_if.op_valid = 1'b0;
    check_val("abort_busy_start", int'(bus_if.busy), 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("abort_d", int'(bus_if.d_out), 0);
    check_val("abort_busy", int'(bus_if.busy), 0);
    check_val("abort_done", int'(bus_if.done), 0);
    check_val("abort_ready", int'(bus_if.op_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    exp_d = 0;
    do_op(0, 8'h09);
    idle_check();

    // Random ops with operand corner values mixed in.
    for (int i = 0; i < 300; i++) begin
      op  = int'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       b = 0;
        1:       b = MAXV;
        2:       b = 1;
        default: b = int'($urandom_range(0, MAXV));
      endcase
      do_op(op, b);
      if ($urandom_range(0, 3) == 0) idle_check();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
